// File: rtl/outer_seq.sv
// outer_seq: outer-interpreter sequencer that walks the terminal input buffer token by token.
// Define OUTER_SEQ_IMM_EN to add fdr_imm_i, which lets immediate words execute while compiling.
module outer_seq #(
   parameter int             MSZ      = 8,
   parameter int             DSZ      = 32,
   parameter int             ASZ      = 17,
   parameter logic [ASZ-1:0] TIB      = ASZ'('h0),
   parameter logic [MSZ-1:0] LIT_OP   = MSZ'('h01),
   parameter logic [ASZ-1:0] HERE_MAX = ASZ'('h1FFFF)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en_i,
   input  logic           compile_i,
   input  logic [ASZ-1:0] here0_i,
   output logic           fdr_en_o,
   output logic [ASZ-1:0] fdr_aw_o,
   input  logic           fdr_bsy_i,
   input  logic           fdr_hit_i,
`ifdef OUTER_SEQ_IMM_EN
   input  logic           fdr_imm_i,
`endif
   input  logic [MSZ-1:0] fdr_vw_i,
   input  logic [ASZ-1:0] fdr_tib_i,
   input  logic [ASZ-1:0] fdr_pfa_i,
   output logic           a2i_en_o,
   output logic [ASZ-1:0] a2i_tib_o,
   input  logic           a2i_bsy_i,
   input  logic           a2i_err_i,
   input  logic [DSZ-1:0] a2i_vo_i,
   input  logic [ASZ-1:0] a2i_end_i,
   output logic           exe_en_o,
   input  logic           exe_bsy_i,
   output logic [ASZ-1:0] exe_pfa_o,
   output logic [MSZ-1:0] exe_op_o,
   output logic           ss_push_o,
   output logic [DSZ-1:0] ss_vi_o,
   input  logic           ss_full_i,
   output logic           mem_we_o,
   output logic [ASZ-1:0] mem_ai_o,
   output logic [MSZ-1:0] mem_vi_o,
   output logic [ASZ-1:0] here_o,
   output logic [ASZ-1:0] tib_o,
   output logic           bsy_o,
   output logic           done_o,
   output logic           err_o,
   output logic [1:0]     err_code_o
);

   localparam int             NB       = DSZ / MSZ;
   localparam int             CW       = $clog2(NB + 1);
   localparam logic [ASZ:0]   HERE_LIM = {1'b0, HERE_MAX};
   localparam logic [ASZ:0]   NB_X     = (ASZ + 1)'(NB);
   localparam logic [CW-1:0]  CNT_LAST = CW'(NB);

   typedef enum logic [2:0] {IDL, FND, EXE, CMA, NUM, A2I, PSH, ERR} state_t;

   state_t         st_q;
   logic           first_q;
   logic [ASZ-1:0] tib_q;
   logic [ASZ-1:0] tokStart_q;
   logic [ASZ:0]   here_q;
   logic [ASZ-1:0] pfa_q;
   logic [MSZ-1:0] op_q;
   logic [DSZ-1:0] val_q;
   logic [CW-1:0]  cnt_q;
   logic           comp_q;
   logic           done_q;
   logic           err_q;
   logic [1:0]     errCode_q;

   logic immHit;
   logic fdrDone;
   logic a2iDone;
   logic exeDone;
   logic cmaFull;
   logic numFull;

`ifdef OUTER_SEQ_IMM_EN
   assign immHit = fdr_imm_i;
`else
   assign immHit = 1'b0;
`endif

   // Engine busy is ignored on the entry cycle so a stale low bsy cannot end a handshake early.
   assign fdrDone = !first_q && !fdr_bsy_i;
   assign a2iDone = !first_q && !a2i_bsy_i;
   assign exeDone = !first_q && !exe_bsy_i;

   // here_q carries an extra bit so a write at HERE_MAX can never wrap back to address zero.
   assign cmaFull = here_q > HERE_LIM;
   assign numFull = (here_q + NB_X) > HERE_LIM;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= IDL;
         first_q    <= 1'b0;
         tib_q      <= TIB;
         tokStart_q <= '0;
         here_q     <= '0;
         pfa_q      <= '0;
         op_q       <= '0;
         val_q      <= '0;
         cnt_q      <= '0;
         comp_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         errCode_q  <= 2'd0;
      end else begin
         first_q <= 1'b0;
         done_q  <= 1'b0;
         if (!en_i) begin
            st_q      <= IDL;
            err_q     <= 1'b0;
            errCode_q <= 2'd0;
         end else begin
            case (st_q)
               IDL: begin
                  st_q    <= FND;
                  first_q <= 1'b1;
                  here_q  <= {1'b0, here0_i};
                  tib_q   <= TIB;
               end
               FND: begin
                  if (fdrDone) begin
                     tib_q      <= fdr_tib_i;
                     tokStart_q <= tib_q;
                     pfa_q      <= fdr_pfa_i;
                     op_q       <= fdr_vw_i;
                     comp_q     <= compile_i;
                     if (fdr_hit_i) begin
                        if (compile_i && !immHit) begin
                           if (cmaFull) begin
                              st_q      <= ERR;
                              err_q     <= 1'b1;
                              errCode_q <= 2'd3;
                              tib_q     <= TIB;
                           end else begin
                              st_q <= CMA;
                           end
                        end else begin
                           st_q    <= EXE;
                           first_q <= 1'b1;
                        end
                     end else if (fdr_vw_i != '0) begin
                        st_q    <= A2I;
                        first_q <= 1'b1;
                     end else begin
                        st_q   <= IDL;
                        tib_q  <= TIB;
                        done_q <= 1'b1;
                     end
                  end
               end
               EXE: begin
                  if (exeDone) begin
                     st_q    <= FND;
                     first_q <= 1'b1;
                  end
               end
               CMA: begin
                  here_q  <= here_q + 1'b1;
                  st_q    <= FND;
                  first_q <= 1'b1;
               end
               A2I: begin
                  if (a2iDone) begin
                     if (a2i_err_i) begin
                        st_q      <= ERR;
                        err_q     <= 1'b1;
                        errCode_q <= 2'd1;
                        tib_q     <= TIB;
                     end else if (comp_q && numFull) begin
                        st_q      <= ERR;
                        err_q     <= 1'b1;
                        errCode_q <= 2'd3;
                        tib_q     <= TIB;
                     end else if (!comp_q && ss_full_i) begin
                        st_q      <= ERR;
                        err_q     <= 1'b1;
                        errCode_q <= 2'd2;
                        tib_q     <= TIB;
                     end else begin
                        tib_q <= a2i_end_i;
                        val_q <= a2i_vo_i;
                        cnt_q <= '0;
                        st_q  <= comp_q ? NUM : PSH;
                     end
                  end
               end
               PSH: begin
                  st_q    <= FND;
                  first_q <= 1'b1;
               end
               NUM: begin
                  // Byte 0 is the literal opcode; the value then goes out least significant byte first.
                  here_q <= here_q + 1'b1;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q != '0) begin
                     val_q <= val_q >> MSZ;
                  end
                  if (cnt_q == CNT_LAST) begin
                     st_q    <= FND;
                     first_q <= 1'b1;
                  end
               end
               ERR: begin
                  st_q <= ERR;
               end
               default: begin
                  st_q <= IDL;
               end
            endcase
         end
      end
   end

   assign bsy_o      = st_q != IDL;
   assign fdr_en_o   = st_q == FND;
   assign fdr_aw_o   = fdr_en_o ? tib_q : '0;
   assign a2i_en_o   = st_q == A2I;
   assign a2i_tib_o  = a2i_en_o ? tokStart_q : '0;
   assign exe_en_o   = st_q == EXE;
   assign exe_pfa_o  = exe_en_o ? pfa_q : '0;
   assign exe_op_o   = exe_en_o ? op_q : '0;
   assign ss_push_o  = st_q == PSH;
   assign ss_vi_o    = ss_push_o ? val_q : '0;
   assign mem_we_o   = (st_q == CMA) || (st_q == NUM);
   assign mem_ai_o   = mem_we_o ? here_q[ASZ-1:0] : '0;
   assign here_o     = here_q[ASZ-1:0];
   assign tib_o      = tib_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_code_o = errCode_q;

   always_comb begin
      mem_vi_o = '0;
      if (st_q == CMA) begin
         mem_vi_o = op_q;
      end else if (st_q == NUM) begin
         mem_vi_o = (cnt_q == '0) ? LIT_OP : val_q[MSZ-1:0];
      end
   end

endmodule

// File: tb/tb_outer_seq.sv
// tb_outer_seq: table-driven bench for outer_seq with finder/atoi/inner-interpreter responders.
// Built against the default configuration (OUTER_SEQ_IMM_EN undefined).
module tb_outer_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_i = 1'b0;
   logic        compile_i = 1'b0;
   logic [16:0] here0_i = '0;
   logic        fdr_en_o;
   logic [16:0] fdr_aw_o;
   logic        fdr_bsy_i = 1'b0;
   logic        fdr_hit_i = 1'b0;
   logic [7:0]  fdr_vw_i = '0;
   logic [16:0] fdr_tib_i = '0;
   logic [16:0] fdr_pfa_i = '0;
   logic        a2i_en_o;
   logic [16:0] a2i_tib_o;
   logic        a2i_bsy_i = 1'b0;
   logic        a2i_err_i = 1'b0;
   logic [31:0] a2i_vo_i = '0;
   logic [16:0] a2i_end_i = '0;
   logic        exe_en_o;
   logic        exe_bsy_i = 1'b0;
   logic [16:0] exe_pfa_o;
   logic [7:0]  exe_op_o;
   logic        ss_push_o;
   logic [31:0] ss_vi_o;
   logic        ss_full_i = 1'b0;
   logic        mem_we_o;
   logic [16:0] mem_ai_o;
   logic [7:0]  mem_vi_o;
   logic [16:0] here_o;
   logic [16:0] tib_o;
   logic        bsy_o;
   logic        done_o;
   logic        err_o;
   logic [1:0]  err_code_o;

   outer_seq dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .compile_i  (compile_i),
      .here0_i    (here0_i),
      .fdr_en_o   (fdr_en_o),
      .fdr_aw_o   (fdr_aw_o),
      .fdr_bsy_i  (fdr_bsy_i),
      .fdr_hit_i  (fdr_hit_i),
      .fdr_vw_i   (fdr_vw_i),
      .fdr_tib_i  (fdr_tib_i),
      .fdr_pfa_i  (fdr_pfa_i),
      .a2i_en_o   (a2i_en_o),
      .a2i_tib_o  (a2i_tib_o),
      .a2i_bsy_i  (a2i_bsy_i),
      .a2i_err_i  (a2i_err_i),
      .a2i_vo_i   (a2i_vo_i),
      .a2i_end_i  (a2i_end_i),
      .exe_en_o   (exe_en_o),
      .exe_bsy_i  (exe_bsy_i),
      .exe_pfa_o  (exe_pfa_o),
      .exe_op_o   (exe_op_o),
      .ss_push_o  (ss_push_o),
      .ss_vi_o    (ss_vi_o),
      .ss_full_i  (ss_full_i),
      .mem_we_o   (mem_we_o),
      .mem_ai_o   (mem_ai_o),
      .mem_vi_o   (mem_vi_o),
      .here_o     (here_o),
      .tib_o      (tib_o),
      .bsy_o      (bsy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_code_o (err_code_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic [7:0]  vw;
      logic [16:0] pfa;
      logic [16:0] tibA;
      logic [31:0] num;
      logic        aerr;
      logic [16:0] aend;
   } tok_t;

   typedef struct {
      logic        comp;
      logic        ssFull;
      logic [16:0] here0;
      int          nTok;
      tok_t        t0;
      tok_t        t1;
      int          ePush;
      logic [31:0] eV0;
      logic [31:0] eV1;
      int          eWr;
      logic [16:0] eA0;
      logic [7:0]  eD0;
      logic        chkHere;
      logic [16:0] eHere;
      logic [1:0]  eErr;
      int          eExe;
      logic [16:0] ePfa;
      logic [7:0]  eOp;
      logic        chkA2i;
      logic [16:0] eA2iTib;
   } vec_t;

   int nAssert = 0;
   int nFail = 0;

   tok_t tokArr[4];
   int   tokIdx = 0;
   int   curTok = 0;
   int   fdrWait = 0;
   int   a2iWait = 0;
   int   exeWait = 0;
   bit   exeHold = 1'b0;

   int          wrCnt = 0;
   int          pushCnt = 0;
   int          exeCnt = 0;
   logic [16:0] wrA[8];
   logic [7:0]  wrD[8];
   logic [31:0] pushV[4];
   logic [16:0] exePfaSeen = '0;
   logic [7:0]  exeOpSeen = '0;
   logic [16:0] a2iTibSeen = '0;
   bit          exePrev = 1'b0;

   vec_t vecs[$];

   function automatic tok_t mkHit(input logic [7:0] op, input logic [16:0] pfa, input logic [16:0] tibA);
      tok_t t;
      t.hit = 1'b1; t.vw = op; t.pfa = pfa; t.tibA = tibA;
      t.num = '0; t.aerr = 1'b0; t.aend = '0;
      return t;
   endfunction

   function automatic tok_t mkNum(input logic [7:0] ch, input logic [16:0] tibA, input logic [31:0] num, input logic aerr);
      tok_t t;
      t.hit = 1'b0; t.vw = ch; t.pfa = '0; t.tibA = tibA;
      t.num = num; t.aerr = aerr; t.aend = tibA;
      return t;
   endfunction

   function automatic tok_t mkEnd();
      tok_t t;
      t.hit = 1'b0; t.vw = 8'h00; t.pfa = '0; t.tibA = 17'h1F;
      t.num = '0; t.aerr = 1'b0; t.aend = '0;
      return t;
   endfunction

   function automatic vec_t mkVec(input logic comp, input logic ssFull, input logic [16:0] here0,
                                  input int nTok, input tok_t t0, input tok_t t1);
      vec_t v;
      v.comp = comp; v.ssFull = ssFull; v.here0 = here0; v.nTok = nTok; v.t0 = t0; v.t1 = t1;
      v.ePush = 0; v.eV0 = '0; v.eV1 = '0; v.eWr = 0; v.eA0 = '0; v.eD0 = '0;
      v.chkHere = 1'b1; v.eHere = here0; v.eErr = 2'd0; v.eExe = 0; v.ePfa = '0; v.eOp = '0;
      v.chkA2i = 1'b0; v.eA2iTib = '0;
      return v;
   endfunction

   // Engine models: each engine shows a stale "finished" response on its entry cycle, then busy, then the answer.
   always @(negedge clk) begin
      if (fdr_en_o) begin
         if (fdrWait == 0) begin
            fdr_bsy_i = 1'b0; fdr_hit_i = 1'b0; fdr_vw_i = 8'h00; fdrWait = 1;
         end else if (fdrWait == 1) begin
            fdr_bsy_i = 1'b1; fdrWait = 2;
         end else if (fdrWait == 2) begin
            tok_t tk;
            tk = (tokIdx < 4) ? tokArr[tokIdx] : mkEnd();
            curTok = (tokIdx < 4) ? tokIdx : 3;
            fdr_bsy_i = 1'b0; fdr_hit_i = tk.hit; fdr_vw_i = tk.vw;
            fdr_pfa_i = tk.pfa; fdr_tib_i = tk.tibA; fdrWait = 3;
         end
      end else if (fdrWait != 0) begin
         fdrWait = 0; tokIdx++; fdr_bsy_i = 1'b0;
      end

      if (a2i_en_o) begin
         if (a2iWait == 0) begin
            a2i_bsy_i = 1'b0; a2i_err_i = 1'b1; a2iWait = 1;
         end else if (a2iWait == 1) begin
            a2i_bsy_i = 1'b1; a2i_err_i = 1'b0; a2iWait = 2;
         end else if (a2iWait == 2) begin
            a2i_bsy_i = 1'b0; a2i_err_i = tokArr[curTok].aerr;
            a2i_vo_i = tokArr[curTok].num; a2i_end_i = tokArr[curTok].aend;
            a2iTibSeen = a2i_tib_o; a2iWait = 3;
         end
      end else begin
         a2iWait = 0; a2i_bsy_i = 1'b0; a2i_err_i = 1'b0;
      end

      if (exe_en_o) begin
         if (exeWait == 0) begin
            exe_bsy_i = 1'b0; exeWait = 1;
         end else if (exeWait == 1) begin
            exe_bsy_i = 1'b1; exeWait = 2;
         end else begin
            exe_bsy_i = exeHold;
         end
      end else begin
         exeWait = 0; exe_bsy_i = 1'b0;
      end
   end

   // Monitor: logs dictionary writes, stack pushes and inner-interpreter invocations.
   always @(negedge clk) begin
      if (mem_we_o) begin
         if (wrCnt < 8) begin
            wrA[wrCnt] = mem_ai_o; wrD[wrCnt] = mem_vi_o;
         end
         wrCnt++;
      end
      if (ss_push_o) begin
         if (pushCnt < 4) pushV[pushCnt] = ss_vi_o;
         pushCnt++;
      end
      if (exe_en_o && !exePrev) begin
         exeCnt++; exePfaSeen = exe_pfa_o; exeOpSeen = exe_op_o;
      end
      exePrev = exe_en_o;
   end

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic prepare(input vec_t v);
      for (int k = 0; k < 4; k++) begin
         tokArr[k] = mkEnd();
      end
      if (v.nTok > 0) tokArr[0] = v.t0;
      if (v.nTok > 1) tokArr[1] = v.t1;
      tokIdx = 0; curTok = 0; fdrWait = 0; a2iWait = 0; exeWait = 0;
      wrCnt = 0; pushCnt = 0; exeCnt = 0; exePrev = 1'b0; a2iTibSeen = '0;
      compile_i = v.comp; ss_full_i = v.ssFull; here0_i = v.here0;
   endtask

   task automatic waitFor(input string nm, input int which, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #2;
         if ((which == 0 && (done_o || err_o)) || (which == 1 && exe_en_o) || (which == 2 && mem_we_o)) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({nm, ".reached"}, 32'(seen), 32'd1);
   endtask

   task automatic applyStimulus(input int i);
      vec_t  v;
      bit    seen;
      string p;
      v = vecs[i];
      p = $sformatf("v%0d", i);
      prepare(v);
      en_i = 1'b1;
      waitFor(p, 0, seen);
      checkOutput({p, ".err_code"}, 32'(err_code_o), 32'(v.eErr));
      checkOutput({p, ".err"}, 32'(err_o), 32'(v.eErr != 2'd0));
      checkOutput({p, ".done"}, 32'(done_o), 32'(v.eErr == 2'd0));
      checkOutput({p, ".bsy"}, 32'(bsy_o), 32'(v.eErr != 2'd0));
      checkOutput({p, ".tib"}, 32'(tib_o), 32'h0);
      checkOutput({p, ".pushes"}, 32'(pushCnt), 32'(v.ePush));
      if (v.ePush > 0) checkOutput({p, ".push0"}, pushV[0], v.eV0);
      if (v.ePush > 1) checkOutput({p, ".push1"}, pushV[1], v.eV1);
      checkOutput({p, ".writes"}, 32'(wrCnt), 32'(v.eWr));
      if (v.eWr > 0) begin
         checkOutput({p, ".wr0_addr"}, 32'(wrA[0]), 32'(v.eA0));
         checkOutput({p, ".wr0_data"}, 32'(wrD[0]), 32'(v.eD0));
      end
      if (v.chkHere) checkOutput({p, ".here"}, 32'(here_o), 32'(v.eHere));
      checkOutput({p, ".exe_count"}, 32'(exeCnt), 32'(v.eExe));
      if (v.eExe > 0) begin
         checkOutput({p, ".exe_pfa"}, 32'(exePfaSeen), 32'(v.ePfa));
         checkOutput({p, ".exe_op"}, 32'(exeOpSeen), 32'(v.eOp));
      end
      if (v.chkA2i) checkOutput({p, ".a2i_tib"}, 32'(a2iTibSeen), 32'(v.eA2iTib));
      en_i = 1'b0;
      @(posedge clk); #2;
      checkOutput({p, ".idle_bsy"}, 32'(bsy_o), 32'd0);
      checkOutput({p, ".idle_err"}, 32'(err_o), 32'd0);
      checkOutput({p, ".idle_done"}, 32'(done_o), 32'd0);
      @(posedge clk); #2;
   endtask

   initial begin
      vec_t        v;
      bit          seen;
      logic [7:0]  litBytes[5];

      // Vector table: single lines of one or two tokens with hand-computed results.
      v = mkVec(1'b0, 1'b0, 17'h050, 2, mkNum(8'h31, 17'd3, 32'd123, 1'b0), mkNum(8'h34, 17'd7, 32'd456, 1'b0));
      v.ePush = 2; v.eV0 = 32'd123; v.eV1 = 32'd456; v.chkA2i = 1'b1; v.eA2iTib = 17'd3;
      vecs.push_back(v);
      v = mkVec(1'b1, 1'b0, 17'h100, 1, mkHit(8'h2A, 17'h300, 17'd4), mkEnd());
      v.eWr = 1; v.eA0 = 17'h100; v.eD0 = 8'h2A; v.eHere = 17'h101;
      vecs.push_back(v);
      v = mkVec(1'b0, 1'b0, 17'h010, 1, mkHit(8'h33, 17'h1234, 17'd5), mkEnd());
      v.eExe = 1; v.ePfa = 17'h1234; v.eOp = 8'h33;
      vecs.push_back(v);
      v = mkVec(1'b1, 1'b0, 17'h200, 1, mkNum(8'h32, 17'd3, 32'd258, 1'b0), mkEnd());
      v.eWr = 5; v.eA0 = 17'h200; v.eD0 = 8'h01; v.eHere = 17'h205; v.chkA2i = 1'b1; v.eA2iTib = 17'd0;
      vecs.push_back(v);
      v = mkVec(1'b0, 1'b0, 17'h000, 1, mkNum(8'h31, 17'd3, 32'h99, 1'b1), mkEnd());
      v.eErr = 2'd1;
      vecs.push_back(v);
      v = mkVec(1'b0, 1'b1, 17'h000, 1, mkNum(8'h37, 17'd1, 32'd7, 1'b0), mkEnd());
      v.eErr = 2'd2;
      vecs.push_back(v);
      v = mkVec(1'b1, 1'b0, 17'h1FFFD, 1, mkNum(8'h39, 17'd1, 32'd9, 1'b0), mkEnd());
      v.eErr = 2'd3;
      vecs.push_back(v);
      v = mkVec(1'b1, 1'b0, 17'h1FFFF, 2, mkHit(8'h11, 17'h40, 17'd2), mkHit(8'h22, 17'h50, 17'd4));
      v.eWr = 1; v.eA0 = 17'h1FFFF; v.eD0 = 8'h11; v.eErr = 2'd3; v.chkHere = 1'b0;
      vecs.push_back(v);
      v = mkVec(1'b0, 1'b0, 17'h077, 0, mkEnd(), mkEnd());
      vecs.push_back(v);
      v = mkVec(1'b0, 1'b0, 17'h020, 2, mkHit(8'h44, 17'h400, 17'd3), mkNum(8'h35, 17'd5, 32'd5, 1'b0));
      v.eExe = 1; v.ePfa = 17'h400; v.eOp = 8'h44; v.ePush = 1; v.eV0 = 32'd5;
      v.chkA2i = 1'b1; v.eA2iTib = 17'd3;
      vecs.push_back(v);
      v = mkVec(1'b1, 1'b0, 17'h1FFFB, 1, mkNum(8'h35, 17'd1, 32'd5, 1'b0), mkEnd());
      v.eWr = 5; v.eA0 = 17'h1FFFB; v.eD0 = 8'h01; v.chkHere = 1'b0;
      vecs.push_back(v);

      litBytes[0] = 8'h01; litBytes[1] = 8'h02; litBytes[2] = 8'h01;
      litBytes[3] = 8'h00; litBytes[4] = 8'h00;

      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset.bsy", 32'(bsy_o), 32'd0);
      checkOutput("reset.tib", 32'(tib_o), 32'd0);
      checkOutput("reset.here", 32'(here_o), 32'd0);
      checkOutput("reset.err", 32'(err_o), 32'd0);
      checkOutput("reset.err_code", 32'(err_code_o), 32'd0);
      checkOutput("reset.strobes", 32'({fdr_en_o, a2i_en_o, exe_en_o, ss_push_o, mem_we_o, done_o}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #2;
      checkOutput("reset.idle_no_en", 32'(bsy_o), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(i);
      end

      // Literal 258 compiled: opcode then little-endian value bytes at consecutive addresses.
      applyStimulus(3);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("lit258.addr%0d", k), 32'(wrA[k]), 32'h200 + 32'(k));
         checkOutput($sformatf("lit258.data%0d", k), 32'(wrD[k]), 32'(litBytes[k]));
      end

      // Dropping en after the first literal byte aborts the compile immediately.
      prepare(vecs[3]);
      en_i = 1'b1;
      waitFor("abort_num", 2, seen);
      checkOutput("abort_num.first_ai", 32'(mem_ai_o), 32'h200);
      checkOutput("abort_num.first_vi", 32'(mem_vi_o), 32'h01);
      en_i = 1'b0;
      @(posedge clk); #2;
      checkOutput("abort_num.mem_we", 32'(mem_we_o), 32'd0);
      checkOutput("abort_num.bsy", 32'(bsy_o), 32'd0);
      checkOutput("abort_num.writes", 32'(wrCnt), 32'd1);
      @(posedge clk); #2;

      // Dropping en while the inner interpreter is busy.
      prepare(vecs[2]);
      exeHold = 1'b1;
      en_i = 1'b1;
      waitFor("abort_exe", 1, seen);
      en_i = 1'b0;
      @(posedge clk); #2;
      checkOutput("abort_exe.exe_en", 32'(exe_en_o), 32'd0);
      checkOutput("abort_exe.bsy", 32'(bsy_o), 32'd0);
      exeHold = 1'b0;
      @(posedge clk); #2;

      // Asynchronous reset in the middle of EXE clears outputs without waiting for a clock edge.
      prepare(vecs[2]);
      exeHold = 1'b1;
      en_i = 1'b1;
      waitFor("rst_exe", 1, seen);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_exe.bsy", 32'(bsy_o), 32'd0);
      checkOutput("rst_exe.exe_en", 32'(exe_en_o), 32'd0);
      checkOutput("rst_exe.mem_we", 32'(mem_we_o), 32'd0);
      checkOutput("rst_exe.here", 32'(here_o), 32'd0);
      en_i = 1'b0;
      exeHold = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
